// File: rtl/bilstm_mac_scheduler.sv
// ---------------------------------------------------------------------------
// bilstm_mac_scheduler
//
// Purpose:
//   Drives one hidden-state MAC datapath through a complete BiLSTM sequence.
//   The forward pass visits timesteps 0..L-1, then the backward pass visits
//   L-1..0. For every step the scheduler:
//     - issues a one-cycle mac_start,
//     - counts mac_valid pulses,
//     - waits for mac_done,
//     - checks that exactly OUTS_PER_STEP results were produced.
//   It also exports the direction/time index used to address the weight and
//   hidden-state buffers, and it reports timeout and count-mismatch errors.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   seq_start  start-sequence pulse (honoured only in IDLE/ERROR)
//   seq_len    sequence length L, latched together with seq_start
//   seq_abort  abandon the current sequence (ignored in IDLE/ERROR)
//   mac_valid  MAC output-element valid pulse (counted only in WAIT)
//   mac_done   MAC step-complete pulse (observed only in WAIT)
//   mac_start  one-cycle start to the MAC
//   dir        0 = forward pass, 1 = backward pass
//   time_idx   current timestep
//   step_done  one-cycle pulse per completed step
//   seq_done   one-cycle pulse after both passes complete
//   busy       high in ISSUE/WAIT/ADVANCE/FINISH
//   err        sticky error flag
//   err_code   01 count mismatch, 10 timeout, 11 bad seq_len
// ---------------------------------------------------------------------------
module bilstm_mac_scheduler #(
  parameter int SEQ_LEN_MAX   = 16,
  parameter int TIME_WIDTH    = 4,
  parameter int OUTS_PER_STEP = 100,
  parameter int CNT_WIDTH     = 8,
  parameter int TIMEOUT       = 4096,
  parameter int TO_WIDTH      = 13
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  seq_start,
  input  logic [TIME_WIDTH:0]   seq_len,
  input  logic                  seq_abort,
  input  logic                  mac_valid,
  input  logic                  mac_done,
  output logic                  mac_start,
  output logic                  dir,
  output logic [TIME_WIDTH-1:0] time_idx,
  output logic                  step_done,
  output logic                  seq_done,
  output logic                  busy,
  output logic                  err,
  output logic [1:0]            err_code
);

  // ---------------------------------------------------------------------
  // Constants, each sized to the signal it is compared against
  // ---------------------------------------------------------------------
  localparam logic [TIME_WIDTH:0]   LEN_MAX    = (TIME_WIDTH+1)'(SEQ_LEN_MAX);
  localparam logic [TIME_WIDTH:0]   LEN_ONE    = (TIME_WIDTH+1)'(1);
  localparam logic [TIME_WIDTH-1:0] IDX_ONE    = TIME_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]  CNT_TARGET = CNT_WIDTH'(OUTS_PER_STEP);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE    = CNT_WIDTH'(1);
  localparam logic [TO_WIDTH-1:0]   TO_LAST    = TO_WIDTH'(TIMEOUT - 1);
  localparam logic [TO_WIDTH-1:0]   TO_ONE     = TO_WIDTH'(1);

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_COUNT = 2'b01;
  localparam logic [1:0] ERR_TIME  = 2'b10;
  localparam logic [1:0] ERR_LEN   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_ADVANCE = 3'd3,
    S_FINISH  = 3'd4,
    S_ERROR   = 3'd5
  } state_t;

  state_t                state;
  logic [TIME_WIDTH:0]   len_r;     // latched sequence length L
  logic [CNT_WIDTH-1:0]  vld_cnt;   // mac_valid pulses seen in this step
  logic [TO_WIDTH-1:0]   to_cnt;    // cycles spent in WAIT

  // ---------------------------------------------------------------------
  // Saturating increment of the valid counter. The counter sticks at
  // all-ones, so a runaway MAC cannot wrap back to a "correct" count.
  // ---------------------------------------------------------------------
  function automatic logic [CNT_WIDTH-1:0] sat_inc(
    input logic [CNT_WIDTH-1:0] cnt,
    input logic                 inc
  );
    logic [CNT_WIDTH-1:0] res;
    res = cnt;
    if (inc && (cnt != {CNT_WIDTH{1'b1}})) begin
      res = cnt + CNT_ONE;
    end
    return res;
  endfunction

  // ---------------------------------------------------------------------
  // Combinational decode used by the FSM
  // ---------------------------------------------------------------------
  logic                 len_ok;     // 1 <= seq_len <= SEQ_LEN_MAX
  logic [CNT_WIDTH-1:0] cnt_final;  // count including a same-cycle valid
  logic [TIME_WIDTH:0]  len_last;   // L-1
  logic                 last_fwd;   // forward pass at its final timestep
  logic                 last_bwd;   // backward pass at timestep 0

  always_comb begin
    len_ok    = (seq_len != '0) && (seq_len <= LEN_MAX);
    cnt_final = sat_inc(vld_cnt, mac_valid);
    len_last  = len_r - LEN_ONE;
    last_fwd  = ({1'b0, time_idx} == len_last);
    last_bwd  = (time_idx == '0);
  end

  // ---------------------------------------------------------------------
  // Sequencing FSM. All outputs are registered here: each pulse output is
  // set on the edge that enters the state it belongs to, so mac_start is
  // high exactly while the FSM sits in ISSUE, step_done while in ADVANCE
  // and seq_done while in FINISH.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      len_r     <= '0;
      vld_cnt   <= '0;
      to_cnt    <= '0;
      mac_start <= 1'b0;
      dir       <= 1'b0;
      time_idx  <= '0;
      step_done <= 1'b0;
      seq_done  <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      // Pulse outputs default low; individual transitions raise them.
      mac_start <= 1'b0;
      step_done <= 1'b0;
      seq_done  <= 1'b0;

      case (state)
        S_IDLE, S_ERROR: begin
          if (seq_start) begin
            if (len_ok) begin
              len_r     <= seq_len;
              dir       <= 1'b0;
              time_idx  <= '0;
              err       <= 1'b0;
              err_code  <= ERR_NONE;
              busy      <= 1'b1;
              mac_start <= 1'b1;
              state     <= S_ISSUE;
            end else begin
              // A rejected length never reaches the MAC.
              err      <= 1'b1;
              err_code <= ERR_LEN;
              busy     <= 1'b0;
              state    <= S_ERROR;
            end
          end
        end

        S_ISSUE: begin
          if (seq_abort) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            vld_cnt <= '0;
            to_cnt  <= '0;
            state   <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (seq_abort) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            vld_cnt <= cnt_final;
            to_cnt  <= to_cnt + TO_ONE;
            // mac_done is checked first so that a done landing on the
            // timeout cycle still completes the step.
            if (mac_done) begin
              if (cnt_final == CNT_TARGET) begin
                step_done <= 1'b1;
                state     <= S_ADVANCE;
              end else begin
                err      <= 1'b1;
                err_code <= ERR_COUNT;
                busy     <= 1'b0;
                state    <= S_ERROR;
              end
            end else if (to_cnt == TO_LAST) begin
              err      <= 1'b1;
              err_code <= ERR_TIME;
              busy     <= 1'b0;
              state    <= S_ERROR;
            end
          end
        end

        S_ADVANCE: begin
          if (seq_abort) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else if (!dir) begin
            // The turnaround keeps time_idx at L-1 so the backward pass
            // starts on the same timestep the forward pass ended on.
            if (last_fwd) begin
              dir <= 1'b1;
            end else begin
              time_idx <= time_idx + IDX_ONE;
            end
            mac_start <= 1'b1;
            state     <= S_ISSUE;
          end else if (!last_bwd) begin
            time_idx  <= time_idx - IDX_ONE;
            mac_start <= 1'b1;
            state     <= S_ISSUE;
          end else begin
            // dir/time_idx are left at (1,0) after the last step.
            seq_done <= 1'b1;
            state    <= S_FINISH;
          end
        end

        S_FINISH: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bilstm_mac_scheduler.sv
// ---------------------------------------------------------------------------
// tb_bilstm_mac_scheduler
//
// Directed bench for bilstm_mac_scheduler with default parameters. A small
// MAC model answers every mac_start with a programmable number of valid
// pulses followed by a done, and a monitor records each mac_start's
// (dir, time_idx) and counts step_done/seq_done pulses. Inputs are driven
// and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_bilstm_mac_scheduler;

  logic       clk;
  logic       rst;
  logic       seq_start;
  logic [4:0] seq_len;
  logic       seq_abort;
  logic       mac_valid;
  logic       mac_done;
  logic       mac_start;
  logic       dir;
  logic [3:0] time_idx;
  logic       step_done;
  logic       seq_done;
  logic       busy;
  logic       err;
  logic [1:0] err_code;

  int n_tests = 0;
  int n_fail  = 0;

  bilstm_mac_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .seq_start (seq_start),
    .seq_len   (seq_len),
    .seq_abort (seq_abort),
    .mac_valid (mac_valid),
    .mac_done  (mac_done),
    .mac_start (mac_start),
    .dir       (dir),
    .time_idx  (time_idx),
    .step_done (step_done),
    .seq_done  (seq_done),
    .busy      (busy),
    .err       (err),
    .err_code  (err_code)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- MAC model ----------------
  int m_valids [8];
  int m_gap;
  bit m_coincide;
  bit m_never;
  bit m_phase;
  int m_rem;
  int m_gcnt;
  int m_step;

  initial begin
    mac_valid = 1'b0;
    mac_done  = 1'b0;
    forever begin
      @(negedge clk);
      mac_valid = 1'b0;
      mac_done  = 1'b0;
      if (m_phase) begin
        if (m_coincide && m_rem == 1) begin
          mac_valid = 1'b1;
          mac_done  = 1'b1;
          m_rem     = 0;
          m_phase   = 1'b0;
        end else if (m_rem > 0) begin
          mac_valid = 1'b1;
          m_rem--;
        end else if (m_gcnt > 0) begin
          m_gcnt--;
        end else if (!m_never) begin
          mac_done = 1'b1;
          m_phase  = 1'b0;
        end
      end
      if (mac_start) begin
        m_phase = 1'b1;
        m_rem   = m_valids[(m_step < 8) ? m_step : 7];
        m_gcnt  = m_gap;
        m_step++;
      end
    end
  end

  // ---------------- Monitor ----------------
  int ms_n, sd_n, sq_n, stab_err, tm_err;
  bit ms_dir [64];
  int ms_t   [64];
  bit last_dir;
  int last_t;
  bit prev_sd;
  bit done_smp;

  initial forever begin
    @(posedge clk);
    done_smp = mac_done;
  end

  initial forever begin
    @(negedge clk);
    if (mac_start) begin
      if (ms_n < 64) begin
        ms_dir[ms_n] = dir;
        ms_t[ms_n]   = int'(time_idx);
      end
      ms_n++;
      last_dir = dir;
      last_t   = int'(time_idx);
    end
    if (step_done) begin
      sd_n++;
      if (dir !== last_dir || int'(time_idx) != last_t) stab_err++;
    end
    if (seq_done) sq_n++;
    // After step_done the next cycle must be either mac_start or seq_done.
    if (prev_sd && !(mac_start || seq_done)) tm_err++;
    // A sampled mac_done must yield step_done (or an error) one cycle later.
    if (done_smp && !step_done && !err) tm_err++;
    prev_sd = step_done;
  end

  task automatic clear_all();
    m_phase    = 1'b0;
    m_rem      = 0;
    m_gcnt     = 0;
    m_step     = 0;
    m_gap      = 5;
    m_coincide = 1'b0;
    m_never    = 1'b0;
    for (int i = 0; i < 8; i++) m_valids[i] = 100;
    repeat (2) @(negedge clk);
    ms_n = 0; sd_n = 0; sq_n = 0; stab_err = 0; tm_err = 0; prev_sd = 1'b0;
  endtask

  // Drives seq_start for one cycle; returns on the negedge where an
  // accepted start shows mac_start.
  task automatic start_seq(input int len);
    seq_len   = len[4:0];
    seq_start = 1'b1;
    @(negedge clk);
    seq_start = 1'b0;
  endtask

  task automatic wait_end(input int max_cyc, input string name);
    int n;
    n = 0;
    while (sq_n == 0 && !err && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    n_tests++;
    if (n >= max_cyc) begin
      n_fail++;
      $display("FAIL %s_bound: waited %0d cycles, required end before %0d", name, n, max_cyc);
    end
  endtask

  // ---------------- Tests ----------------
  task automatic test_reset();
    rst = 1'b1; seq_start = 1'b0; seq_abort = 1'b0; seq_len = '0;
    clear_all();
    repeat (2) @(negedge clk);
    n_tests++;
    if ({mac_start, dir, time_idx, step_done, seq_done, busy, err, err_code} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 000",
               {mac_start, dir, time_idx, step_done, seq_done, busy, err, err_code});
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({mac_start, busy, err} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_release_idle: got %b required 000", {mac_start, busy, err});
    end
  endtask

  task automatic test_l3();
    int ed [6] = '{0, 0, 0, 1, 1, 1};
    int et [6] = '{0, 1, 2, 2, 1, 0};
    clear_all();
    start_seq(3);
    n_tests++;
    if ({mac_start, busy, dir, time_idx} !== 7'b1100000) begin
      n_fail++;
      $display("FAIL l3_start_latency: got %b required 1100000", {mac_start, busy, dir, time_idx});
    end
    wait_end(3000, "l3");
    n_tests++;
    if (ms_n != 6) begin n_fail++; $display("FAIL l3_mac_starts: got %0d required 6", ms_n); end
    for (int i = 0; i < 6; i++) begin
      n_tests++;
      if (int'(ms_dir[i]) != ed[i] || ms_t[i] != et[i]) begin
        n_fail++;
        $display("FAIL l3_index_%0d: got (%0d,%0d) required (%0d,%0d)", i, ms_dir[i], ms_t[i], ed[i], et[i]);
      end
    end
    n_tests++;
    if (sd_n != 6 || sq_n != 1) begin
      n_fail++;
      $display("FAIL l3_pulses: got step_done=%0d seq_done=%0d required 6 and 1", sd_n, sq_n);
    end
    n_tests++;
    if (stab_err != 0 || tm_err != 0) begin
      n_fail++;
      $display("FAIL l3_timing: got stability errs=%0d timing errs=%0d required 0 and 0", stab_err, tm_err);
    end
    n_tests++;
    if ({err, busy, dir, time_idx} !== 7'b0010000) begin
      n_fail++;
      $display("FAIL l3_final_state: got err,busy,dir,t=%b required 0010000", {err, busy, dir, time_idx});
    end
  endtask

  task automatic test_l1_coincident();
    clear_all();
    m_coincide = 1'b1;
    start_seq(1);
    wait_end(1000, "l1");
    n_tests++;
    if (ms_n != 2 || ms_dir[0] != 1'b0 || ms_t[0] != 0 || ms_dir[1] != 1'b1 || ms_t[1] != 0) begin
      n_fail++;
      $display("FAIL l1_steps: got n=%0d (%0d,%0d)(%0d,%0d) required 2 (0,0)(1,0)",
               ms_n, ms_dir[0], ms_t[0], ms_dir[1], ms_t[1]);
    end
    n_tests++;
    if (err !== 1'b0 || sq_n != 1 || sd_n != 2) begin
      n_fail++;
      $display("FAIL l1_coincident_valid: got err=%b seq_done=%0d step_done=%0d required 0,1,2", err, sq_n, sd_n);
    end
  endtask

  task automatic test_count_mismatch();
    clear_all();
    m_valids[1] = 99;
    start_seq(3);
    wait_end(1000, "mismatch");
    n_tests++;
    if ({err, err_code, busy} !== 4'b1010) begin
      n_fail++;
      $display("FAIL mismatch_err: got err,code,busy=%b required 1010", {err, err_code, busy});
    end
    repeat (200) @(negedge clk);
    n_tests++;
    if (ms_n != 2 || sd_n != 1 || sq_n != 0 || err !== 1'b1) begin
      n_fail++;
      $display("FAIL mismatch_halt: got starts=%0d steps=%0d seqs=%0d err=%b required 2,1,0,1", ms_n, sd_n, sq_n, err);
    end
  endtask

  task automatic test_recover();
    clear_all();
    start_seq(2);
    n_tests++;
    if ({err, err_code, mac_start} !== 4'b0001) begin
      n_fail++;
      $display("FAIL recover_clear: got err,code,mac_start=%b required 0001", {err, err_code, mac_start});
    end
    wait_end(2000, "recover");
    n_tests++;
    if (ms_n != 4 || sq_n != 1 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL recover_run: got starts=%0d seqs=%0d err=%b required 4,1,0", ms_n, sq_n, err);
    end
  endtask

  task automatic test_timeout();
    int n;
    clear_all();
    m_never = 1'b1;
    start_seq(2);
    n = 0;
    while (!err && n < 5000) begin
      @(negedge clk);
      n++;
    end
    n_tests++;
    if (n != 4097) begin
      n_fail++;
      $display("FAIL timeout_cycles: got err after %0d cycles required 4097", n);
    end
    n_tests++;
    if ({err, err_code, busy} !== 4'b1100 || ms_n != 1) begin
      n_fail++;
      $display("FAIL timeout_code: got err,code,busy=%b starts=%0d required 1100 and 1", {err, err_code, busy}, ms_n);
    end
  endtask

  task automatic test_bad_len();
    clear_all();
    start_seq(0);
    n_tests++;
    if ({err, err_code, mac_start, busy} !== 5'b11100) begin
      n_fail++;
      $display("FAIL badlen_0: got err,code,start,busy=%b required 11100", {err, err_code, mac_start, busy});
    end
    start_seq(16);
    n_tests++;
    if ({err, mac_start, busy} !== 3'b011) begin
      n_fail++;
      $display("FAIL len16_accept: got err,start,busy=%b required 011", {err, mac_start, busy});
    end
    seq_abort = 1'b1;
    @(negedge clk);
    seq_abort = 1'b0;
    clear_all();
    start_seq(17);
    n_tests++;
    if ({err, err_code, mac_start, busy} !== 5'b11100) begin
      n_fail++;
      $display("FAIL badlen_17: got err,code,start,busy=%b required 11100", {err, err_code, mac_start, busy});
    end
    repeat (20) @(negedge clk);
    n_tests++;
    if (ms_n != 0) begin n_fail++; $display("FAIL badlen_no_start: got %0d mac_start required 0", ms_n); end
  endtask

  task automatic test_abort();
    int n;
    clear_all();
    start_seq(3);
    n = 0;
    while (ms_n < 3 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    repeat (10) @(negedge clk);
    seq_abort = 1'b1;
    @(negedge clk);
    seq_abort = 1'b0;
    n_tests++;
    if ({busy, mac_start, step_done, err} !== 4'b0000) begin
      n_fail++;
      $display("FAIL abort_idle: got busy,start,step,err=%b required 0000", {busy, mac_start, step_done, err});
    end
    repeat (300) @(negedge clk);
    n_tests++;
    if (ms_n != 3 || sd_n != 2 || sq_n != 0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_quiet: got starts=%0d steps=%0d seqs=%0d err=%b required 3,2,0,0", ms_n, sd_n, sq_n, err);
    end
  endtask

  task automatic test_rst_mid_issue();
    clear_all();
    start_seq(2);
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({mac_start, dir, time_idx, step_done, seq_done, busy, err, err_code} !== 12'h000) begin
      n_fail++;
      $display("FAIL async_rst: got %h required 000",
               {mac_start, dir, time_idx, step_done, seq_done, busy, err, err_code});
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    n_tests++;
    if (ms_n != 1 || busy !== 1'b0 || sq_n != 0) begin
      n_fail++;
      $display("FAIL rst_idle: got starts=%0d busy=%b seqs=%0d required 1,0,0", ms_n, busy, sq_n);
    end
  endtask

  initial begin
    test_reset();
    test_l3();
    test_l1_coincident();
    test_count_mismatch();
    test_recover();
    test_timeout();
    test_bad_len();
    test_abort();
    test_rst_mid_issue();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bilstm_mac_scheduler.md
# bilstm_mac_scheduler

Sequences one hidden-state MAC datapath across a full BiLSTM sequence: forward timesteps 0..L-1, then backward timesteps L-1..0. Per step it issues a one-cycle start, counts result-valid pulses, waits for done, and checks the count. It sits between the top-level sequence control and the gate MAC units. It also provides the direction/time index used for weight and hidden-state buffer addressing, plus timeout and count-mismatch error reporting.

## Interface
Parameters:
- SEQ_LEN_MAX, 16, maximum sequence length L
- TIME_WIDTH, 4, width of time index (clog2(SEQ_LEN_MAX))
- OUTS_PER_STEP, 100, mac_valid pulses expected per step (COLS_B of MAC)
- CNT_WIDTH, 8, width of valid counter
- TIMEOUT, 4096, max cycles in WAIT before error
- TO_WIDTH, 13, width of timeout counter

Ports:
- clk  in  1  clock, all logic rising-edge
- rst  in  1  asynchronous, active-high reset
- seq_start  in  1  start-sequence pulse, sampled in IDLE/ERROR only
- seq_len  in  TIME_WIDTH+1  sequence length, latched with seq_start
- seq_abort  in  1  abandon current sequence
- mac_valid  in  1  MAC output-element valid pulse
- mac_done  in  1  MAC step-complete pulse
- mac_start  out  1  one-cycle start to MAC
- dir  out  1  0 = forward, 1 = backward
- time_idx  out  TIME_WIDTH  current timestep
- step_done  out  1  one-cycle pulse per completed step
- seq_done  out  1  one-cycle pulse at end of both passes
- busy  out  1  high in ISSUE/WAIT/ADVANCE/FINISH
- err  out  1  sticky error flag
- err_code  out  2  01 count mismatch, 10 timeout, 11 bad seq_len

## Operation
- States: IDLE, ISSUE, WAIT, ADVANCE, FINISH, ERROR. All outputs are registered. Reset (async) forces IDLE and all outputs to 0.
- IDLE/ERROR + seq_start:
  - If 1 ≤ seq_len ≤ SEQ_LEN_MAX: latch L, dir=0, time_idx=0, clear err/err_code, go to ISSUE.
  - Otherwise go to (or stay in) ERROR with err=1, err_code=11. No mac_start is issued.
- ISSUE: mac_start=1 for this cycle only. Clear the valid counter and timeout counter. Go to WAIT.
- WAIT:
  - Each mac_valid increments the valid counter, saturating at all-ones.
  - The timeout counter increments every cycle.
  - On mac_done: the final count includes a mac_valid arriving in the same cycle. If the count equals OUTS_PER_STEP, go to ADVANCE; otherwise go to ERROR with err_code=01.
  - If the timeout counter reaches TIMEOUT-1 without mac_done, go to ERROR with err_code=10.
  - If mac_done and timeout occur in the same cycle, mac_done wins.
- ADVANCE: step_done=1, then the index updates:
  - dir=0 and time_idx<L-1: time_idx+1, go to ISSUE.
  - dir=0 and time_idx=L-1: dir←1, time_idx unchanged (L-1), go to ISSUE.
  - dir=1 and time_idx>0: time_idx-1, go to ISSUE.
  - dir=1 and time_idx=0: go to FINISH.
- FINISH: seq_done=1 for one cycle, go to IDLE. dir and time_idx hold their last values.
- ERROR: err=1 with err_code held; busy=0. Leaves only on an accepted seq_start or on reset.
- seq_abort in ISSUE/WAIT/ADVANCE/FINISH: next state is IDLE. No step_done or seq_done is issued. err is unchanged. seq_abort has priority over every other transition; it is ignored in IDLE/ERROR.
- mac_valid and mac_done outside WAIT are ignored.
- seq_start while busy is ignored.

## Timing
- seq_start sampled at edge N → ISSUE at N+1 (mac_start high in cycle N+1); WAIT from N+2.
- mac_done sampled at edge M → step_done high in cycle M+1; next mac_start at M+2, with the new dir/time_idx already valid.
- Per-step overhead is 3 cycles beyond the MAC latency (ISSUE, done-sample, ADVANCE).
- Sequence total is 2L steps. seq_done asserts one cycle after the last step_done.
- dir and time_idx are stable from the mac_start cycle through that step's step_done.

## Test plan
- L=3, MAC model gives 100 valids then done 5 cycles later → 6 mac_start pulses with (dir,t) = (0,0),(0,1),(0,2),(1,2),(1,1),(1,0); 6 step_done; 1 seq_done; err=0.
- L=1 → exactly two steps, (0,0) then (1,0), then seq_done. mac_valid coincident with mac_done is counted.
- Step 2 delivers 99 valids → ERROR after that done; err=1, err_code=01, busy=0, no further mac_start. A later seq_start with L=2 clears err and runs normally.
- MAC never asserts done → after TIMEOUT cycles in WAIT, err_code=10.
- seq_len=0 and seq_len=17 → err_code=11, zero mac_start pulses.
- seq_abort during WAIT of step 3 → IDLE next cycle, no seq_done. Async rst asserted mid-ISSUE → all outputs 0 immediately, state IDLE.
